stream_ctrl_multi: RTL and testbench

STREAM_CTRL_MULTI -- requirements
Module: stream_ctrl_multi

---
 rtl/stream_ctrl_multi.sv | 172 +++++++++++++++++
 tb/tb_stream_ctrl_multi.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_ctrl_multi.sv
// ---------------------------------------------------------------------------
// stream_ctrl_multi
//
// Frame-granular gate for a parallel-channel sensor pixel stream. Each frame
// is judged once, at its fval rising edge: it is forwarded whole when stream
// enable, acquisition start and encrypt state are all high and the frame
// budget is not yet used up; otherwise it is suppressed whole. Forwarded
// frames leave with a fixed two-cycle latency and unchanged fval/lval timing.
//
// Parameters
//   DATA_WIDTH   bits per pixel per channel
//   CHANNEL_NUM  pixel channels carried side by side on the data bus
//   REG_WD       width of the frame budget and the forwarded-frame counter
//
// Ports
//   clk_pix              pixel clock (only clock)
//   reset_pix_n          asynchronous active-low reset
//   i_fval / i_lval      sensor frame / line valid
//   iv_pix_data          sensor pixel data, channel 0 in the low bits
//   i_stream_enable      stream enable
//   i_acquisition_start  acquisition start
//   i_encrypt_state      encrypt OK
//   iv_frame_num         frames to pass per acquisition, 0 = unlimited
//   o_fval / o_lval      gated frame / line valid
//   ov_pix_data          gated pixel data, zero outside gated lines
//   o_full_frame_state   high while a frame is being forwarded
//   o_frame_done         one-cycle pulse after a forwarded frame ends
//   ov_frame_cnt         frames forwarded since acquisition (re)started
// ---------------------------------------------------------------------------
module stream_ctrl_multi #(
    parameter int DATA_WIDTH  = 10,
    parameter int CHANNEL_NUM = 1,
    parameter int REG_WD      = 32
) (
    input  logic                              clk_pix,
    input  logic                              reset_pix_n,
    input  logic                              i_fval,
    input  logic                              i_lval,
    input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
    input  logic                              i_stream_enable,
    input  logic                              i_acquisition_start,
    input  logic                              i_encrypt_state,
    input  logic [REG_WD-1:0]                 iv_frame_num,
    output logic                              o_fval,
    output logic                              o_lval,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic                              o_full_frame_state,
    output logic                              o_frame_done,
    output logic [REG_WD-1:0]                 ov_frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        SKIP = 2'd2
    } state_t;

    state_t             state_reg;
    logic               fval_d1_reg;
    logic               lval_d1_reg;
    logic               fval_out_reg;
    logic               lval_out_reg;
    logic               full_frame_reg;
    logic               frame_done_reg;
    logic [REG_WD-1:0]  frame_cnt_reg;

    logic               fval_rise;
    logic               fval_fall;
    logic               enable;
    logic               frame_allowed;
    logic               cnt_clear;
    logic               fval_gate;
    logic               lval_gate;

    // Edges are taken between the live input and its stage-1 copy, so a
    // frame that is low for a single cycle still yields a fall and a rise.
    assign fval_rise     = i_fval & ~fval_d1_reg;
    assign fval_fall     = ~i_fval & fval_d1_reg;
    assign enable        = i_stream_enable & i_acquisition_start & i_encrypt_state;
    assign frame_allowed = (iv_frame_num == '0) || (frame_cnt_reg < iv_frame_num);
    assign cnt_clear     = ~i_acquisition_start | ~i_stream_enable;

    // Gating terms are built from stage-1 values; the state changes on the
    // same edge that loads stage 1, so the whole frame sees a stable decision.
    assign fval_gate = fval_d1_reg & (state_reg == PASS);
    assign lval_gate = lval_d1_reg & fval_gate;

    // Frame decision FSM together with the outputs derived from it.
    always_ff @(posedge clk_pix or negedge reset_pix_n) begin
        if (!reset_pix_n) begin
            state_reg      <= IDLE;
            full_frame_reg <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            full_frame_reg <= (state_reg == PASS);

            case (state_reg)
                IDLE: begin
                    if (fval_rise) begin
                        state_reg <= (enable && frame_allowed) ? PASS : SKIP;
                    end
                end
                PASS: begin
                    if (fval_fall) begin
                        state_reg <= IDLE;
                    end
                end
                SKIP: begin
                    if (fval_fall) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Clearing wins over counting a frame that ends in the same cycle.
            if (cnt_clear) begin
                frame_cnt_reg <= '0;
            end else if ((state_reg == PASS) && fval_fall && (frame_cnt_reg != '1)) begin
                frame_cnt_reg <= frame_cnt_reg + {{(REG_WD-1){1'b0}}, 1'b1};
            end
        end
    end

    // Control half of the stage-1 and output pipeline.
    always_ff @(posedge clk_pix or negedge reset_pix_n) begin
        if (!reset_pix_n) begin
            // Treat fval as already high so a frame in flight at reset
            // release is not mistaken for a fresh rise.
            fval_d1_reg    <= 1'b1;
            lval_d1_reg    <= 1'b0;
            fval_out_reg   <= 1'b0;
            lval_out_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            fval_d1_reg    <= i_fval;
            lval_d1_reg    <= i_lval;
            fval_out_reg   <= fval_gate;
            lval_out_reg   <= lval_gate;
            // Falling edge of the registered output fval, seen one cycle late.
            frame_done_reg <= fval_out_reg & ~fval_gate;
        end
    end

    // Data half of the pipeline, one slice per channel.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNEL_NUM; gi++) begin : g_chan
            logic [DATA_WIDTH-1:0] pix_d1_reg;
            logic [DATA_WIDTH-1:0] pix_out_reg;

            always_ff @(posedge clk_pix or negedge reset_pix_n) begin
                if (!reset_pix_n) begin
                    pix_d1_reg  <= '0;
                    pix_out_reg <= '0;
                end else begin
                    pix_d1_reg  <= iv_pix_data[gi*DATA_WIDTH +: DATA_WIDTH];
                    pix_out_reg <= lval_gate ? pix_d1_reg : '0;
                end
            end

            assign ov_pix_data[gi*DATA_WIDTH +: DATA_WIDTH] = pix_out_reg;
        end
    endgenerate

    assign o_fval             = fval_out_reg;
    assign o_lval             = lval_out_reg;
    assign o_full_frame_state = full_frame_reg;
    assign o_frame_done       = frame_done_reg;
    assign ov_frame_cnt       = frame_cnt_reg;

endmodule

// File: tb/tb_stream_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_stream_ctrl_multi
//
// Scoreboard bench for stream_ctrl_multi with four 10-bit channels. The
// frame driver decides, from its own view of the control inputs and its own
// frame count, whether each frame should come out; for those frames it
// queues the expected start cycle, length and every beat. The monitor opens
// an expected window at the queued start cycle and compares o_fval,
// o_full_frame_state, o_frame_done, o_lval and ov_pix_data every cycle.
// ---------------------------------------------------------------------------
module tb_stream_ctrl_multi;

    localparam int DW = 10;
    localparam int CN = 4;
    localparam int RW = 32;
    localparam int PW = DW * CN;

    logic          clk_pix = 1'b0;
    logic          reset_pix_n;
    logic          i_fval;
    logic          i_lval;
    logic [PW-1:0] iv_pix_data;
    logic          i_stream_enable;
    logic          i_acquisition_start;
    logic          i_encrypt_state;
    logic [RW-1:0] iv_frame_num;
    logic          o_fval;
    logic          o_lval;
    logic [PW-1:0] ov_pix_data;
    logic          o_full_frame_state;
    logic          o_frame_done;
    logic [RW-1:0] ov_frame_cnt;

    stream_ctrl_multi #(
        .DATA_WIDTH  (DW),
        .CHANNEL_NUM (CN),
        .REG_WD      (RW)
    ) dut (
        .clk_pix             (clk_pix),
        .reset_pix_n         (reset_pix_n),
        .i_fval              (i_fval),
        .i_lval              (i_lval),
        .iv_pix_data         (iv_pix_data),
        .i_stream_enable     (i_stream_enable),
        .i_acquisition_start (i_acquisition_start),
        .i_encrypt_state     (i_encrypt_state),
        .iv_frame_num        (iv_frame_num),
        .o_fval              (o_fval),
        .o_lval              (o_lval),
        .ov_pix_data         (ov_pix_data),
        .o_full_frame_state  (o_full_frame_state),
        .o_frame_done        (o_frame_done),
        .ov_frame_cnt        (ov_frame_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int rise;
        int len;
    } frame_t;

    typedef struct {
        logic          lval;
        logic [PW-1:0] data;
    } beat_t;

    frame_t frame_q[$];
    beat_t  beat_q[$];

    int cyc       = 0;
    int n_checks  = 0;
    int n_errors  = 0;
    int exp_cnt   = 0;
    int done_cnt  = 0;
    int frame_idx = 0;
    bit mon_en    = 1'b0;

    always @(posedge clk_pix) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic rand_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        iv_pix_data = r[PW-1:0];
    endtask

    task automatic set_se(input bit v);
        i_stream_enable = v;
        if (!v) exp_cnt = 0;
    endtask

    task automatic set_acq(input bit v);
        i_acquisition_start = v;
        if (!v) exp_cnt = 0;
    endtask

    // One frame: 'lines' lines of 'bpl' active beats plus 'hgap' blank beats,
    // all under fval, then 'tail' cycles of fval low. Optionally changes
    // stream enable at beat 'se_at' of the frame.
    task automatic drive_frame(input int lines, input int bpl, input int hgap, input int tail,
                               input int se_at = -1, input bit se_val = 1'b0);
        bit fwd;
        int len;
        int idx;
        fwd = i_stream_enable && i_acquisition_start && i_encrypt_state &&
              ((iv_frame_num == 0) || (exp_cnt < int'(iv_frame_num)));
        len = lines * (bpl + hgap);
        if (fwd) frame_q.push_back('{cyc + 2, len});
        idx = 0;
        for (int l = 0; l < lines; l++) begin
            for (int b = 0; b < bpl + hgap; b++) begin
                if (idx == se_at) begin
                    if (se_val) i_stream_enable = 1'b1;
                    else        set_se(1'b0);
                end
                i_fval = 1'b1;
                i_lval = (b < bpl);
                rand_data();
                if (fwd) beat_q.push_back('{i_lval, i_lval ? iv_pix_data : '0});
                tick();
                idx++;
            end
        end
        i_fval = 1'b0;
        for (int t = 0; t < tail; t++) begin
            i_lval = 1'($urandom_range(0, 1));
            rand_data();
            tick();
        end
        i_lval = 1'b0;
        if (fwd) exp_cnt = (i_stream_enable && i_acquisition_start) ? exp_cnt + 1 : 0;
        $display("frame %0d: %0d cycles high, forwarded=%0d, model count=%0d",
                 frame_idx, len, fwd, exp_cnt);
        frame_idx++;
    endtask

    // Monitor
    frame_t mon_cur;
    beat_t  mon_beat;
    int     mon_left     = 0;
    bit     mon_win      = 1'b0;
    bit     mon_done_pnd = 1'b0;
    bit     mon_exp_done;

    always @(negedge clk_pix) begin
        if (!reset_pix_n) begin
            check_value("rst_fval", o_fval, 0);
            check_value("rst_lval", o_lval, 0);
            check_value("rst_data", ov_pix_data, 0);
            check_value("rst_full", o_full_frame_state, 0);
            check_value("rst_done", o_frame_done, 0);
            check_value("rst_cnt", ov_frame_cnt, 0);
            mon_win      = 1'b0;
            mon_done_pnd = 1'b0;
        end else if (mon_en) begin
            mon_exp_done = mon_done_pnd;
            mon_done_pnd = 1'b0;
            if (!mon_win && frame_q.size() > 0 && frame_q[0].rise < cyc) begin
                check_value("frame_start", cyc, frame_q[0].rise);
                void'(frame_q.pop_front());
            end
            if (!mon_win && frame_q.size() > 0 && frame_q[0].rise == cyc) begin
                mon_cur  = frame_q.pop_front();
                mon_win  = 1'b1;
                mon_left = mon_cur.len;
            end
            check_value("o_fval", o_fval, mon_win);
            check_value("full_frame", o_full_frame_state, mon_win);
            check_value("frame_done", o_frame_done, mon_exp_done);
            if (o_frame_done) done_cnt++;
            if (mon_win) begin
                if (beat_q.size() > 0) begin
                    mon_beat = beat_q.pop_front();
                    check_value("o_lval", o_lval, mon_beat.lval);
                    check_value("pix_data", ov_pix_data, mon_beat.data);
                end
                mon_left--;
                if (mon_left == 0) begin
                    mon_win      = 1'b0;
                    mon_done_pnd = 1'b1;
                end
            end
        end
    end

    int d0;

    initial begin
        reset_pix_n         = 1'b0;
        i_fval              = 1'b0;
        i_lval              = 1'b0;
        iv_pix_data         = '0;
        i_stream_enable     = 1'b1;
        i_acquisition_start = 1'b1;
        i_encrypt_state     = 1'b1;
        iv_frame_num        = '0;
        repeat (3) tick();
        reset_pix_n = 1'b1;
        mon_en      = 1'b1;
        repeat (3) tick();
        check_value("cnt_after_reset", ov_frame_cnt, 0);

        // Continuous mode, 30 frames of 64 lines x 64 pixels (16 beats x 4 channels).
        d0 = done_cnt;
        repeat (30) drive_frame(64, 16, 1, 2);
        repeat (4) tick();
        check_value("cnt_30_frames", ov_frame_cnt, 30);
        check_value("done_30_frames", done_cnt - d0, 30);

        // Frames 1, 2 and 3 cycles long separated by 1-cycle gaps.
        d0 = done_cnt;
        drive_frame(1, 1, 0, 1);
        drive_frame(1, 2, 0, 1);
        drive_frame(1, 2, 1, 1);
        repeat (4) tick();
        check_value("done_short_frames", done_cnt - d0, 3);
        check_value("cnt_short_frames", ov_frame_cnt, exp_cnt);

        // Stream enable alternating at every frame start.
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            set_se((i % 2) == 0);
            drive_frame(4, 3, 1, 2);
        end
        set_se(1'b1);
        repeat (4) tick();
        check_value("done_se_toggle", done_cnt - d0, 3);

        // Enable rising mid-frame, then falling mid-frame.
        d0 = done_cnt;
        set_se(1'b0);
        drive_frame(4, 3, 1, 2, 5, 1'b1);
        drive_frame(4, 3, 1, 2, 5, 1'b0);
        drive_frame(2, 3, 1, 2);
        set_se(1'b1);
        repeat (4) tick();
        check_value("done_se_mid", done_cnt - d0, 1);
        check_value("cnt_se_mid", ov_frame_cnt, 0);

        // Frame budget of 3.
        iv_frame_num = 32'd3;
        set_acq(1'b0);
        tick();
        set_acq(1'b1);
        tick();
        d0 = done_cnt;
        repeat (6) drive_frame(3, 4, 1, 2);
        repeat (4) tick();
        check_value("cnt_budget", ov_frame_cnt, 3);
        check_value("done_budget", done_cnt - d0, 3);
        set_acq(1'b0);
        tick();
        check_value("cnt_acq_clear", ov_frame_cnt, 0);
        set_acq(1'b1);
        d0 = done_cnt;
        repeat (4) drive_frame(3, 4, 1, 2);
        repeat (4) tick();
        check_value("cnt_budget_again", ov_frame_cnt, 3);
        check_value("done_budget_again", done_cnt - d0, 3);

        // Encrypt state low blocks a frame but leaves the count alone.
        iv_frame_num = '0;
        d0 = done_cnt;
        i_encrypt_state = 1'b0;
        drive_frame(2, 4, 1, 2);
        i_encrypt_state = 1'b1;
        drive_frame(2, 4, 1, 2);
        repeat (4) tick();
        check_value("done_encrypt", done_cnt - d0, 1);
        check_value("cnt_encrypt", ov_frame_cnt, exp_cnt);

        // Reset in the middle of a forwarded frame, released with fval high.
        mon_en = 1'b0;
        i_fval = 1'b1;
        i_lval = 1'b1;
        repeat (5) begin
            rand_data();
            tick();
        end
        check_value("fval_before_rst", o_fval, 1);
        reset_pix_n = 1'b0;
        #1;
        check_value("async_fval", o_fval, 0);
        check_value("async_lval", o_lval, 0);
        check_value("async_data", ov_pix_data, 0);
        check_value("async_full", o_full_frame_state, 0);
        check_value("async_cnt", ov_frame_cnt, 0);
        exp_cnt = 0;
        frame_q.delete();
        beat_q.delete();
        repeat (3) tick();
        reset_pix_n = 1'b1;
        mon_en      = 1'b1;
        repeat (5) begin
            rand_data();
            tick();
        end
        i_fval = 1'b0;
        i_lval = 1'b0;
        repeat (2) tick();
        d0 = done_cnt;
        drive_frame(3, 4, 1, 2);
        repeat (4) tick();
        check_value("done_after_rst", done_cnt - d0, 1);
        check_value("cnt_after_rst", ov_frame_cnt, 1);

        repeat (4) tick();
        check_value("frame_q_empty", frame_q.size(), 0);
        check_value("beat_q_empty", beat_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
